// File: rtl/if_fetch_pkg.sv
// Shared fetch/decode definitions: reset PC, sequential step, bubble
// instruction, fetch FSM encoding and the base opcodes decode switches on.
package if_fetch_pkg;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int unsigned PC_STEP   = 4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

    localparam int unsigned XLEN = 32;

    // Fetch FSM encoding
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } fetch_state_t;

    // Base opcodes used by the decode stage
    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_OP_IMM = 7'b0010011,
        OPC_OP     = 7'b0110011
    } opcode_t;

endpackage

// File: rtl/if_fetch.sv
// Instruction-fetch stage. Owns the fetch PC, issues instruction-memory
// requests and drives the IF/ID register. A one-entry hold buffer keeps a
// returned instruction while decode is stalled; a request outstanding when
// decode redirects is completed on the bus and its data discarded.
//
// Ports:
//   clk, reset_n            clock, async active-low reset
//   stall                   decode stalled, IF/ID holds
//   control_j, pc_j         one-cycle redirect and its target
//   imem_req, imem_addr     memory request (address stable until ack)
//   imem_ack, imem_rdata    memory response (same-cycle ack allowed)
//   pipe_pc, pipe_data,
//   pipe_valid              IF/ID register
module if_fetch #(
    parameter logic [31:0] RESET_PC  = if_fetch_pkg::RESET_PC,
    parameter int unsigned PC_STEP   = if_fetch_pkg::PC_STEP,
    parameter logic [31:0] NOP_INSTR = if_fetch_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        control_j,
    input  logic [31:0] pc_j,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pipe_pc,
    output logic [31:0] pipe_data,
    output logic        pipe_valid
);

    import if_fetch_pkg::fetch_state_t;
    import if_fetch_pkg::S_IDLE;
    import if_fetch_pkg::S_REQ;
    import if_fetch_pkg::S_HOLD;
    import if_fetch_pkg::S_DROP;

    localparam logic [31:0] STEP = 32'(PC_STEP);

    fetch_state_t state, state_nxt;
    logic [31:0]  fetch_pc, fetch_pc_nxt;
    logic [31:0]  req_addr, req_addr_nxt;
    logic [31:0]  redir_pc, redir_pc_nxt;
    logic [31:0]  hold_pc, hold_pc_nxt;
    logic [31:0]  hold_data, hold_data_nxt;
    logic [31:0]  pipe_pc_nxt, pipe_data_nxt;
    logic         pipe_valid_nxt;
    logic         imem_req_nxt;
    logic [31:0]  imem_addr_nxt;
    logic [31:0]  jump_target;

    // Redirect targets are word aligned
    assign jump_target = pc_j & ~32'h0000_0003;

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            fetch_pc   <= RESET_PC;
            req_addr   <= '0;
            redir_pc   <= '0;
            hold_pc    <= '0;
            hold_data  <= '0;
            pipe_pc    <= '0;
            pipe_data  <= NOP_INSTR;
            pipe_valid <= 1'b0;
            imem_req   <= 1'b0;
            imem_addr  <= RESET_PC;
        end else begin
            state      <= state_nxt;
            fetch_pc   <= fetch_pc_nxt;
            req_addr   <= req_addr_nxt;
            redir_pc   <= redir_pc_nxt;
            hold_pc    <= hold_pc_nxt;
            hold_data  <= hold_data_nxt;
            pipe_pc    <= pipe_pc_nxt;
            pipe_data  <= pipe_data_nxt;
            pipe_valid <= pipe_valid_nxt;
            imem_req   <= imem_req_nxt;
            imem_addr  <= imem_addr_nxt;
        end
    end

    // Next state; priority is redirect, then stall, then normal flow
    always_comb begin
        state_nxt      = state;
        fetch_pc_nxt   = fetch_pc;
        req_addr_nxt   = req_addr;
        redir_pc_nxt   = redir_pc;
        hold_pc_nxt    = hold_pc;
        hold_data_nxt  = hold_data;
        pipe_pc_nxt    = pipe_pc;
        pipe_data_nxt  = pipe_data;
        pipe_valid_nxt = pipe_valid;

        // A redirect always flushes IF/ID, even under stall
        if (control_j) begin
            pipe_data_nxt  = NOP_INSTR;
            pipe_valid_nxt = 1'b0;
        end

        case (state)
            S_IDLE: begin
                state_nxt = S_REQ;
                if (control_j) begin
                    fetch_pc_nxt = jump_target;
                end
            end

            S_REQ: begin
                if (control_j) begin
                    if (imem_ack) begin
                        fetch_pc_nxt = jump_target;
                    end else begin
                        // Let the outstanding request finish, then drop it
                        req_addr_nxt = fetch_pc;
                        redir_pc_nxt = jump_target;
                        state_nxt    = S_DROP;
                    end
                end else if (imem_ack) begin
                    fetch_pc_nxt = fetch_pc + STEP;
                    if (stall) begin
                        hold_pc_nxt   = fetch_pc;
                        hold_data_nxt = imem_rdata;
                        state_nxt     = S_HOLD;
                    end else begin
                        pipe_pc_nxt    = fetch_pc;
                        pipe_data_nxt  = imem_rdata;
                        pipe_valid_nxt = 1'b1;
                    end
                end else if (!stall) begin
                    pipe_data_nxt  = NOP_INSTR;
                    pipe_valid_nxt = 1'b0;
                end
            end

            S_HOLD: begin
                if (control_j) begin
                    fetch_pc_nxt = jump_target;
                    state_nxt    = S_REQ;
                end else if (!stall) begin
                    pipe_pc_nxt    = hold_pc;
                    pipe_data_nxt  = hold_data;
                    pipe_valid_nxt = 1'b1;
                    state_nxt      = S_REQ;
                end
            end

            S_DROP: begin
                if (control_j) begin
                    redir_pc_nxt = jump_target;
                end else if (!stall) begin
                    pipe_data_nxt  = NOP_INSTR;
                    pipe_valid_nxt = 1'b0;
                end
                if (imem_ack) begin
                    fetch_pc_nxt = redir_pc_nxt;
                    state_nxt    = S_REQ;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Bus outputs follow the state being entered
        imem_req_nxt  = (state_nxt == S_REQ) || (state_nxt == S_DROP);
        imem_addr_nxt = (state_nxt == S_DROP) ? req_addr_nxt : fetch_pc_nxt;
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch. Memory returns rdata = 0xA000_0000 ^ addr
// and acks in the request cycle whenever the bench enables it.
module tb_if_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset_n, reset_n1;
    logic        stall, control_j;
    logic [31:0] pc_j;
    logic        ack_en;

    logic        imem_req, imem_ack, pipe_valid;
    logic [31:0] imem_addr, imem_rdata, pipe_pc, pipe_data;

    logic        imem_req1, imem_ack1, pipe_valid1;
    logic [31:0] imem_addr1, imem_rdata1, pipe_pc1, pipe_data1;

    int n_checks;
    int n_fail;

    assign imem_ack    = ack_en & imem_req;
    assign imem_rdata  = 32'hA000_0000 ^ imem_addr;
    assign imem_ack1   = imem_req1;
    assign imem_rdata1 = 32'hA000_0000 ^ imem_addr1;

    if_fetch dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .stall      (stall),
        .control_j  (control_j),
        .pc_j       (pc_j),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .pipe_pc    (pipe_pc),
        .pipe_data  (pipe_data),
        .pipe_valid (pipe_valid)
    );

    if_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk        (clk),
        .reset_n    (reset_n1),
        .stall      (1'b0),
        .control_j  (1'b0),
        .pc_j       (32'h0),
        .imem_req   (imem_req1),
        .imem_addr  (imem_addr1),
        .imem_ack   (imem_ack1),
        .imem_rdata (imem_rdata1),
        .pipe_pc    (pipe_pc1),
        .pipe_data  (pipe_data1),
        .pipe_valid (pipe_valid1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset_n   = 1'b0;
        reset_n1  = 1'b0;
        stall     = 1'b0;
        control_j = 1'b0;
        pc_j      = '0;
        ack_en    = 1'b1;

        // Reset state
        #12;
        check("rst_valid", 32'(pipe_valid), 32'h0);
        check("rst_data",  pipe_data, NOP);
        check("rst_pc",    pipe_pc, 32'h0);
        check("rst_req",   32'(imem_req), 32'h0);

        // Same-cycle acks: one instruction per cycle after the idle cycle
        reset_n = 1'b1;
        step();
        check("idle_valid", 32'(pipe_valid), 32'h0);
        check("idle_req",   32'(imem_req), 32'h1);
        check("idle_addr",  imem_addr, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("seq_pc",    pipe_pc, 32'(i * 4));
            check("seq_data",  pipe_data, 32'hA000_0000 ^ 32'(i * 4));
            check("seq_valid", 32'(pipe_valid), 32'h1);
        end
        check("seq_addr", imem_addr, 32'h10);

        // Two-cycle ack latency at 0x10
        ack_en = 1'b0;
        step();
        check("wait1_valid", 32'(pipe_valid), 32'h0);
        check("wait1_addr",  imem_addr, 32'h10);
        check("wait1_pc",    pipe_pc, 32'hC);
        step();
        check("wait2_valid", 32'(pipe_valid), 32'h0);
        check("wait2_addr",  imem_addr, 32'h10);
        ack_en = 1'b1;
        step();
        check("late_pc",    pipe_pc, 32'h10);
        check("late_valid", 32'(pipe_valid), 32'h1);
        check("late_addr",  imem_addr, 32'h14);

        // Ack at 0x14 under a three-cycle stall goes to the hold buffer
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_pc",    pipe_pc, 32'h10);
            check("hold_valid", 32'(pipe_valid), 32'h1);
            check("hold_req",   32'(imem_req), 32'h0);
        end
        stall = 1'b0;
        step();
        check("unhold_pc",   pipe_pc, 32'h14);
        check("unhold_data", pipe_data, 32'hA000_0014);
        check("unhold_addr", imem_addr, 32'h18);
        step();
        check("after_hold_pc", pipe_pc, 32'h18);

        // Redirect while the request at 0x1C waits for its ack
        ack_en = 1'b0;
        step();
        check("pre_j_addr", imem_addr, 32'h1C);
        control_j = 1'b1;
        pc_j      = 32'h100;
        step();
        control_j = 1'b0;
        check("drop_valid", 32'(pipe_valid), 32'h0);
        check("drop_addr",  imem_addr, 32'h1C);
        check("drop_req",   32'(imem_req), 32'h1);
        step();
        check("drop2_addr", imem_addr, 32'h1C);
        ack_en = 1'b1;
        step();
        check("dropped_valid", 32'(pipe_valid), 32'h0);
        check("dropped_data",  pipe_data, NOP);
        check("redir_addr",    imem_addr, 32'h100);
        step();
        check("redir_pc",   pipe_pc, 32'h100);
        check("redir_data", pipe_data, 32'hA000_0100);

        // Redirect and stall in the same cycle, unaligned target
        stall     = 1'b1;
        control_j = 1'b1;
        pc_j      = 32'h0000_0206;
        step();
        stall     = 1'b0;
        control_j = 1'b0;
        check("js_valid", 32'(pipe_valid), 32'h0);
        check("js_data",  pipe_data, NOP);
        check("js_addr",  imem_addr, 32'h204);
        step();
        check("js_pc",    pipe_pc, 32'h204);
        check("js_vld",   32'(pipe_valid), 32'h1);

        // PC wraps past 2^32; async reset mid-request
        reset_n1 = 1'b1;
        step();
        check("wrap_addr0", imem_addr1, 32'hFFFF_FFF8);
        step();
        check("wrap_pc0", pipe_pc1, 32'hFFFF_FFF8);
        step();
        check("wrap_pc1", pipe_pc1, 32'hFFFF_FFFC);
        check("wrap_addr", imem_addr1, 32'h0);
        step();
        check("wrap_pc2", pipe_pc1, 32'h0);
        check("wrap_req", 32'(imem_req1), 32'h1);
        #2;
        reset_n1 = 1'b0;
        #1;
        check("async_req",   32'(imem_req1), 32'h0);
        check("async_valid", 32'(pipe_valid1), 32'h0);
        check("async_data",  pipe_data1, NOP);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
